// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the memory-stage bus master and its
// alignment helper.
//   state_t        : bus master FSM states (IDLE, WAIT, ABORT, DONE)
//   EXC_*          : CP0 exception codes raised by the data-memory access
//   LD_* / ST_*    : encodings of MemOutSelM (load type) and MemInSelM
//                    (store type)
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Load types; codes 5..7 behave as lw.
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LB  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LH  = 3'd4;

    // Store types; code 3 behaves as sw.
    localparam logic [1:0] ST_SW = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SB = 2'd2;

endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: request/acknowledge data bus between the memory-stage
// master and a variable-latency slave.
//   req   : master -> slave, request held until ack
//   we    : master -> slave, write enable
//   addr  : master -> slave, word-aligned address (ADDR_W bits)
//   be    : master -> slave, byte enables
//   wdata : master -> slave, lane-replicated write data
//   ack   : slave -> master, transfer complete
//   rdata : slave -> master, read data, valid with ack
//   err   : slave -> master, error response, valid with ack
interface mem_bus_master_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: purely combinational byte-lane logic for a 32-bit data bus.
// Shared with the instruction-fetch side, so it holds no state.
//   is_store   in   1 : access is a store (selects in_sel), else a load
//   out_sel    in   3 : load type (lw/lbu/lb/lhu/lh, others lw)
//   in_sel     in   2 : store type (sw/sh/sb, 3 = sw)
//   addr_lo    in   2 : low two bits of the effective address
//   wdata_in   in  32 : store data from the pipeline
//   rdata_in   in  32 : raw word returned by the bus
//   be         out  4 : byte enables (1111 for loads)
//   wdata      out 32 : store data replicated across lanes
//   load_data  out 32 : extracted and extended load result
//   misaligned out  1 : address not naturally aligned for the access size
module mem_align
    import mips_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  out_sel,
    input  logic [1:0]  in_sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(rdata_in >> {addr_lo, 3'b000});
    assign half_lane = 16'(rdata_in >> {addr_lo[1], 4'b0000});

    always_comb begin
        be         = 4'b1111;
        wdata      = wdata_in;
        misaligned = 1'b0;
        if (is_store) begin
            case (in_sel)
                ST_SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{wdata_in[15:0]}};
                    misaligned = addr_lo[0];
                end
                ST_SB: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{wdata_in[7:0]}};
                end
                default: misaligned = (addr_lo != 2'b00);
            endcase
        end else begin
            case (out_sel)
                LD_LBU, LD_LB: misaligned = 1'b0;
                LD_LHU, LD_LH: misaligned = addr_lo[0];
                default:       misaligned = (addr_lo != 2'b00);
            endcase
        end
    end

    always_comb begin
        case (out_sel)
            LD_LBU:  load_data = ext_byte(byte_lane, 1'b0);
            LD_LB:   load_data = ext_byte(byte_lane, 1'b1);
            LD_LHU:  load_data = ext_half(half_lane, 1'b0);
            LD_LH:   load_data = ext_half(half_lane, 1'b1);
            default: load_data = rdata_in;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: memory-stage data access on a request/acknowledge bus.
// Stalls the pipeline while an access is outstanding, returns the extended
// load result for one cycle and reports AdEL/AdES/DBE exceptions to CP0.
// Optional feature macro: MEM_TIMEOUT_EN (watchdog on WAIT/ABORT).
//   clk, reset_n           : clock, asynchronous active-low reset
//   respon                 : exception-response flush from CP0
//   MemWriteM, MemOrALUM   : store / load request (store wins)
//   MemOutSelM, MemInSelM  : load type / store type
//   ALUoutM, rd2M          : effective address / store data
//   bus                    : data bus, master side
//   stall                  : freeze PC/F/D/E/M
//   load_data              : extended load result, valid in the DONE cycle
//   exc_valid, exc_code    : exception for the current M instruction
module mem_bus_master
    import mips_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                respon,
    input  logic                MemWriteM,
    input  logic                MemOrALUM,
    input  logic [2:0]          MemOutSelM,
    input  logic [1:0]          MemInSelM,
    input  logic [31:0]         ALUoutM,
    input  logic [31:0]         rd2M,
    mem_bus_master_if.master    bus,
    output logic                stall,
    output logic [31:0]         load_data,
    output logic                exc_valid,
    output logic [4:0]          exc_code
);

    state_t      state, state_nx;
    logic        access;
    logic        err_q;
    logic        timeout;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_mis;
    logic [31:0] word_addr;

    assign access    = MemWriteM | MemOrALUM;
    assign word_addr = {ALUoutM[31:2], 2'b00};

    mem_align u_align (
        .is_store   (MemWriteM),
        .out_sel    (MemOutSelM),
        .in_sel     (MemInSelM),
        .addr_lo    (ALUoutM[1:0]),
        .wdata_in   (rd2M),
        .rdata_in   (bus.rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if (state == IDLE && state_nx == WAIT) begin
            wait_cnt <= 8'd0;
        end else if (state == WAIT || state == ABORT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires in the last permitted WAIT/ABORT cycle so the forced exit lands
    // after exactly TIMEOUT_CYCLES cycles in those states.
    assign timeout = (state == WAIT || state == ABORT) &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build: the expression is constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        exc_valid = 1'b0;
        exc_code  = 5'd0;
        case (state)
            IDLE: begin
                // A flushed instruction neither requests nor faults.
                if (access && !respon) begin
                    if (al_mis) begin
                        exc_valid = 1'b1;
                        exc_code  = MemWriteM ? EXC_ADES : EXC_ADEL;
                    end else begin
                        stall    = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (respon) begin
                    // The bus cannot be cancelled; finish it silently.
                    state_nx = (bus.ack || timeout) ? IDLE : ABORT;
                end else if (bus.ack || timeout) begin
                    state_nx = DONE;
                end
            end
            ABORT: begin
                stall = access;
                if (bus.ack || timeout) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (err_q) begin
                    exc_valid = 1'b1;
                    exc_code  = EXC_DBE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.be    <= 4'd0;
            bus.wdata <= 32'd0;
            load_data <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == WAIT) begin
                bus.req   <= 1'b1;
                bus.we    <= MemWriteM;
                bus.addr  <= word_addr[ADDR_W-1:0];
                bus.be    <= al_be;
                bus.wdata <= al_wdata;
            end
            if ((state == WAIT || state == ABORT) &&
                (state_nx == DONE || state_nx == IDLE)) begin
                bus.req <= 1'b0;
            end
            // A watchdog exit without ack is reported as a bus error.
            if (state == WAIT && state_nx == DONE) begin
                load_data <= al_load;
                err_q     <= bus.err | ~bus.ack;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_LIM = 8;
`else
    localparam int TO_LIM = 255;
`endif

    logic        clk;
    logic        reset_n;
    logic        respon;
    logic        MemWriteM;
    logic        MemOrALUM;
    logic [2:0]  MemOutSelM;
    logic [1:0]  MemInSelM;
    logic [31:0] ALUoutM;
    logic [31:0] rd2M;
    logic        stall;
    logic [31:0] load_data;
    logic        exc_valid;
    logic [4:0]  exc_code;

    int n_vec = 0;
    int n_bad = 0;

    mem_bus_master_if #(.ADDR_W(32)) bus ();

    mem_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_LIM)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .respon     (respon),
        .MemWriteM  (MemWriteM),
        .MemOrALUM  (MemOrALUM),
        .MemOutSelM (MemOutSelM),
        .MemInSelM  (MemInSelM),
        .ALUoutM    (ALUoutM),
        .rd2M       (rd2M),
        .bus        (bus),
        .stall      (stall),
        .load_data  (load_data),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model + driver for one memory-stage instruction.
    // nw = number of WAIT cycles before ack (ack comes in req cycle nw).
    task automatic run_op(input bit we_in, input bit ld_in, input logic [2:0] os,
                          input logic [1:0] is, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int nw, input bit er);
        int          sz, lo, eff;
        bit          is_st, mis, exp_err;
        logic [31:0] exp_be, exp_wd, exp_ld, lane;
        int          stall_cnt, req_cyc;
        bit          done;

        is_st = we_in;
        lo    = int'(a % 4);
        if (is_st) sz = (is == 2'd1) ? 2 : (is == 2'd2) ? 1 : 4;
        else       sz = (os == 3'd1 || os == 3'd2) ? 1 : (os == 3'd3 || os == 3'd4) ? 2 : 4;
        mis = (lo % sz) != 0;
        if (sz == 4) begin
            exp_be = 32'hF;  exp_wd = d;
        end else if (sz == 2) begin
            exp_be = 32'h3 << lo;  exp_wd = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            exp_be = 32'h1 << lo;  exp_wd = (d & 32'hFF) * 32'h0101_0101;
        end
        lane = rd >> (8 * lo);
        if (sz == 1) begin
            exp_ld = lane & 32'hFF;
            if (os == 3'd2 && exp_ld >= 32'd128) exp_ld = exp_ld + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            exp_ld = lane & 32'hFFFF;
            if (os == 3'd4 && exp_ld >= 32'd32768) exp_ld = exp_ld + 32'hFFFF_0000;
        end else begin
            exp_ld = rd;
        end
        eff = nw;  exp_err = er;
        if (nw >= TO_LIM) begin
            eff = TO_LIM - 1;  exp_err = 1'b1;
        end

        @(posedge clk); #1;
        MemWriteM = we_in;  MemOrALUM = ld_in;  MemOutSelM = os;  MemInSelM = is;
        ALUoutM = a;  rd2M = d;  bus.ack = 1'b0;  bus.err = 1'b0;
        #1;
        if (mis) begin
            chk("mis_exc_valid", exc_valid, 1);
            chk("mis_exc_code", exc_code, is_st ? 5 : 4);
            chk("mis_stall", stall, 0);
            @(posedge clk); #1;
            chk("mis_no_req", bus.req, 0);
            MemWriteM = 1'b0;  MemOrALUM = 1'b0;
            return;
        end
        chk("first_exc_valid", exc_valid, 0);
        stall_cnt = 0;  req_cyc = 0;  done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (bus.req) begin
                if (req_cyc == 0) begin
                    chk("addr", bus.addr, a & 32'hFFFF_FFFC);
                    chk("we", bus.we, is_st);
                    if (is_st) begin
                        chk("be", bus.be, exp_be);
                        chk("wdata", bus.wdata, exp_wd);
                    end
                end
                if (req_cyc == nw) begin
                    bus.ack = 1'b1;  bus.rdata = rd;  bus.err = er;
                end else begin
                    bus.ack = 1'b0;  bus.rdata = $urandom;  bus.err = 1'b0;
                end
                req_cyc++;
            end else begin
                bus.ack = 1'b0;
            end
            #1;
            if (stall) begin
                stall_cnt++;
            end else begin
                chk("done_req_low", bus.req, 0);
                chk("done_exc_valid", exc_valid, exp_err);
                if (exp_err) chk("done_exc_code", exc_code, 7);
                else if (!is_st) chk("load_data", load_data, exp_ld);
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        chk("op_finished", done, 1);
        chk("stall_cycles", stall_cnt, eff + 2);
        chk("req_cycles", req_cyc, eff + 1);
        MemWriteM = 1'b0;  MemOrALUM = 1'b0;  bus.ack = 1'b0;  bus.err = 1'b0;
    endtask

    task automatic respon_test();
        logic [31:0] prev_ld;
        @(posedge clk); #1;
        prev_ld = load_data;
        MemWriteM = 1'b0;  MemOrALUM = 1'b1;  MemOutSelM = 3'd0;  ALUoutM = 32'h0000_5004;
        bus.ack = 1'b0;
        #1 chk("abt_idle_stall", stall, 1);
        @(posedge clk); #1;
        chk("abt_wait_req", bus.req, 1);
        respon = 1'b1;
        #1 chk("abt_wait_stall", stall, 1);
        @(posedge clk); #1;
        respon = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MemOrALUM = (i != 1);
            if (i == 3) begin
                bus.ack = 1'b1;  bus.rdata = 32'hDEAD_BEEF;  bus.err = 1'b1;
            end
            #1;
            chk("abt_req_held", bus.req, 1);
            chk("abt_stall_access", stall, (i != 1));
            chk("abt_no_exc", exc_valid, 0);
            @(posedge clk); #1;
        end
        bus.ack = 1'b0;  bus.err = 1'b0;
        #1;
        chk("abt_idle_req", bus.req, 0);
        chk("abt_idle_exc", exc_valid, 0);
        chk("abt_idle_stall2", stall, 1);
        chk("abt_ld_kept", load_data, prev_ld);
        @(posedge clk); #1;
        chk("abt_fresh_req", bus.req, 1);
        chk("abt_fresh_addr", bus.addr, 32'h0000_5004);
        bus.ack = 1'b1;  bus.rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        #1;
        chk("abt_done_stall", stall, 0);
        chk("abt_done_ld", load_data, 32'h1234_5678);
        chk("abt_done_exc", exc_valid, 0);
        MemOrALUM = 1'b0;
    endtask

    initial begin
        bit          w, l;
        logic [2:0]  os;
        logic [1:0]  is;
        reset_n = 1'b0;  respon = 1'b0;  MemWriteM = 1'b0;  MemOrALUM = 1'b0;
        MemOutSelM = 3'd0;  MemInSelM = 2'd0;  ALUoutM = 32'd0;  rd2M = 32'd0;
        bus.ack = 1'b0;  bus.rdata = 32'd0;  bus.err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", bus.req, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_be", bus.be, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_stall", stall, 0);
        reset_n = 1'b1;

        // Directed cases
        run_op(1'b0, 1'b1, 3'd2, 2'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b0);
        run_op(1'b1, 1'b0, 3'd0, 2'd1, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 3, 1'b0);
        run_op(1'b0, 1'b1, 3'd0, 2'd0, 32'h0000_3001, 32'd0, 32'd0, 0, 1'b0);
        run_op(1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_3002, 32'h1111_2222, 32'd0, 0, 1'b0);
        run_op(1'b0, 1'b1, 3'd3, 2'd0, 32'h0000_4000, 32'd0, 32'h0000_8001, 1, 1'b1);
        run_op(1'b1, 1'b1, 3'd2, 2'd2, 32'h0000_6001, 32'h0000_00A5, 32'd0, 2, 1'b0);
        respon_test();

        // respon in IDLE on a misaligned load: no fault, no request
        @(posedge clk); #1;
        MemOrALUM = 1'b1;  MemOutSelM = 3'd0;  ALUoutM = 32'h0000_3001;  respon = 1'b1;
        #1;
        chk("respon_idle_stall", stall, 0);
        chk("respon_idle_exc", exc_valid, 0);
        @(posedge clk); #1;
        chk("respon_idle_req", bus.req, 0);
        respon = 1'b0;  MemOrALUM = 1'b0;

        // Stray ack in IDLE is ignored
        bus.ack = 1'b1;
        #1 chk("stray_ack_stall", stall, 0);
        @(posedge clk); #1;
        chk("stray_ack_req", bus.req, 0);
        bus.ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        run_op(1'b0, 1'b1, 3'd0, 2'd0, 32'h0000_7000, 32'd0, 32'd0, 100000, 1'b0);
`endif

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            w  = ($urandom_range(0, 1) == 1);
            l  = !w || ($urandom_range(0, 3) == 0);
            os = 3'($urandom_range(0, 7));
            is = 2'($urandom_range(0, 3));
            run_op(w, l, os, is, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a transaction
        @(posedge clk); #1;
        MemOrALUM = 1'b1;  MemOutSelM = 3'd0;  ALUoutM = 32'h0000_8000;
        @(posedge clk); #1;
        chk("midrst_req_before", bus.req, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_req", bus.req, 0);
        chk("midrst_addr", bus.addr, 0);
        MemOrALUM = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Consumer side of the E→M pipeline register: takes the memory-stage control and data fields (MemWriteM, MemOrALUM, MemOutSelM, MemInSelM, ALUoutM, rd2M) and runs the data access on a variable-latency request/acknowledge data bus.
- Stalls the pipeline while an access is outstanding and returns the aligned, extended load data to the write-back path.
- Raises address-error and bus-error exception codes for CP0.
- Honours the `respon` flush.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT state (used only when MEM_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- respon  in  1  exception-response flush from CP0
- MemWriteM  in  1  store request
- MemOrALUM  in  1  1 = load request
- MemOutSelM  in  3  load type: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh; others are treated as lw
- MemInSelM  in  2  store type: 0 sw, 1 sh, 2 sb; 3 is treated as sw
- ALUoutM  in  32  effective address
- rd2M  in  32  store data, already forwarded
- bus_req  out  1  request, held until ack
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  word-aligned address: {ALUoutM[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  transfer complete
- bus_rdata  in  32  read data, valid with ack
- bus_err  in  1  error response, valid with ack
- stall  out  1  freeze PC/F/D/E/M
- load_data  out  32  extended load result
- exc_valid  out  1  exception for the current M instruction
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE

Behaviour:
- Reset: state IDLE. Registered outputs return to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data.
- Access condition: access = MemWriteM | MemOrALUM. MemWriteM has priority if both are set.
- Misalignment:
  - word: addr[1:0] != 0
  - half: addr[0] != 0
  - byte: never misaligned
- Misaligned access:
  - exc_valid=1 combinationally, exc_code = 4 for a load, 5 for a store.
  - No bus request is issued and stall=0.
- States:
  - IDLE → WAIT: access & aligned & !respon. On that edge, bus_req/we/addr/be/wdata are registered. stall=1 in the decision cycle.
  - WAIT: bus outputs are held stable and stall=1.
    - On bus_ack, go to DONE. rdata is captured and extended into load_data; bus_err is captured; bus_req drops to 0.
    - On respon in WAIT, go to ABORT. The bus cannot be cancelled.
  - ABORT: bus_req is held until bus_ack, then go to IDLE. rdata and bus_err are discarded. stall = access.
  - DONE: stall=0 and the pipeline advances at this edge.
    - load_data is valid for this cycle only.
    - If a bus_err was captured: exc_valid=1, exc_code=7.
    - Always goes to IDLE, even if access is set. The next instruction is evaluated in IDLE.
- Latency: with a zero-wait slave (ack in the first bus_req cycle), stall is high for 2 cycles and load_data is valid in the 3rd cycle.
- Store byte enables:
  - sw: 1111
  - sh: addr[1] ? 1100 : 0011
  - sb: 0001 << addr[1:0]
- Store write data: sh → {2{rd2[15:0]}}, sb → {4{rd2[7:0]}}.
- Load extraction:
  - byte lane: rdata >> (8·addr[1:0])
  - half lane: rdata >> (16·addr[1])
  - lb/lh sign-extend; lbu/lhu zero-extend
- respon in IDLE: no request, no exception, stall=0.
- bus_ack while bus_req=0 is ignored.
- Reset mid-transaction returns to IDLE immediately; the slave must also be reset.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on WAIT entry and increments in WAIT/ABORT.
  - Reaching TIMEOUT_CYCLES in WAIT forces DONE with a captured error (exc_code 7).
  - Reaching TIMEOUT_CYCLES in ABORT forces IDLE.
  - Either way, bus_req drops.
- Undefined: no counter; the block waits indefinitely for bus_ack.

Decomposition:
- Shared package (`mips_pkg`):
  - state enum (IDLE, WAIT, ABORT, DONE)
  - ExcCode constants: EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7
  - load/store select encodings
- Sub-module `mem_align`: purely combinational. Computes byte enables, write-data replication, load extraction and misalignment detection. Reused by the future instruction-fetch side.

Test Plan:
- lb at 0x1003, zero-wait, rdata=0x80FF_1234 → be=0001 shifted per lane, stall 2 cycles, load_data=0xFFFF_FF80.
- sh at 0x2002, rd2=0x0000_ABCD, 3 wait cycles → be=1100, wdata=0xABCD_ABCD, we=1, stall 5 cycles, no exception.
- lw at 0x3001 → exc_valid=1, code 4, bus_req never asserted, stall=0; sw at 0x3002 → code 5.
- lhu at 0x4000 with bus_err at ack → DONE cycle exc_valid=1, code 7, stall drops.
- respon asserted during WAIT, ack 4 cycles later with a lw pending in M → bus_req held until ack, no load_data/exception, stall follows access, then IDLE and a fresh request.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → exc code 7 after 8 WAIT cycles, bus_req=0.
